// File: rtl/btn_cond.sv
// Four-button conditioner: 2-flop sync, per-bit debounce FSM, registered level/press/release pulses.
// Pulse latency DB_CYCLES+2 edges from first sample; no backpressure. Long-press via BTN_COND_LONGPRESS_EN.
module btn_cond #(
  parameter int DB_CYCLES = 1000000,
  parameter int LP_CYCLES = 100000000
) (
  input  logic       MCLK,
  input  logic       RST_N,
  input  logic [3:0] BTN_IN,
  output logic [3:0] BTN_LVL,
  output logic [3:0] BTN_PRESS,
  output logic [3:0] BTN_REL,
  output logic [3:0] BTN_LONG
);

  localparam int            CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  if (DB_CYCLES < 2 || LP_CYCLES < 1) begin : g_param_chk
    $error("btn_cond: DB_CYCLES must be >= 2 and LP_CYCLES >= 1");
  end

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= BTN_IN;
      sync_q <= meta_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (st_q)
        IDLE: begin
          if (sync_q[i]) begin
            st_d  = PRESS_WAIT;
            cnt_d = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_q[i]) begin
            st_d = IDLE;
          end else if (cnt_q == DB_LAST) begin
            st_d    = HELD;
            lvl_d   = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!sync_q[i]) begin
            st_d  = REL_WAIT;
            cnt_d = '0;
          end
        end
        REL_WAIT: begin
          // A bounce back to 1 returns to HELD silently; the release window restarts on the next drop.
          if (sync_q[i]) begin
            st_d = HELD;
          end else if (cnt_q == DB_LAST) begin
            st_d  = IDLE;
            lvl_d = 1'b0;
            rel_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
      if (!RST_N) begin
        st_q    <= IDLE;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign BTN_LVL[i]   = lvl_q;
    assign BTN_PRESS[i] = press_q;
    assign BTN_REL[i]   = rel_q;

`ifdef BTN_COND_LONGPRESS_EN
    localparam int            LW     = $clog2(LP_CYCLES + 1);
    localparam logic [LW-1:0] LP_MAX = LW'(LP_CYCLES);
    localparam logic [LW-1:0] LP_PRE = LW'(LP_CYCLES - 1);

    logic [LW-1:0] lp_q;
    logic          long_q;

    // Saturating at LP_MAX makes the pulse fire exactly once per press.
    always_ff @(posedge MCLK or negedge RST_N) begin
      if (!RST_N) begin
        lp_q   <= '0;
        long_q <= 1'b0;
      end else if (st_q == HELD || st_q == REL_WAIT) begin
        if (lp_q != LP_MAX) lp_q <= lp_q + 1'b1;
        long_q <= (lp_q == LP_PRE);
      end else begin
        lp_q   <= '0;
        long_q <= 1'b0;
      end
    end

    assign BTN_LONG[i] = long_q;
`else
    assign BTN_LONG[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_cond.sv
// Table-driven bench for btn_cond (DB_CYCLES=4, LP_CYCLES=20); expected vectors pass through a scoreboard queue.
module tb_btn_cond;

  logic       MCLK;
  logic       RST_N;
  logic [3:0] BTN_IN;
  logic [3:0] BTN_LVL, BTN_PRESS, BTN_REL, BTN_LONG;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] lvl;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  btn_cond #(.DB_CYCLES(4), .LP_CYCLES(20)) dut (
    .MCLK      (MCLK),
    .RST_N     (RST_N),
    .BTN_IN    (BTN_IN),
    .BTN_LVL   (BTN_LVL),
    .BTN_PRESS (BTN_PRESS),
    .BTN_REL   (BTN_REL),
    .BTN_LONG  (BTN_LONG)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  function automatic void new_seq(int n, logic [3:0] btn, logic [3:0] lvl);
    vecs.delete();
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.btn = btn; v.press = '0; v.rel = '0; v.lng = '0; v.lvl = lvl;
      vecs.push_back(v);
    end
  endfunction

  function automatic void set_btn(logic [3:0] m, int from, int to, logic val);
    for (int i = from; i <= to; i++)
      vecs[i].btn = val ? (vecs[i].btn | m) : (vecs[i].btn & ~m);
  endfunction

  function automatic void set_lvl(logic [3:0] m, int from, int to, logic val);
    for (int i = from; i <= to; i++)
      vecs[i].lvl = val ? (vecs[i].lvl | m) : (vecs[i].lvl & ~m);
  endfunction

  function automatic void ev_press(logic [3:0] m, int idx);
    vecs[idx].press = vecs[idx].press | m;
  endfunction

  function automatic void ev_rel(logic [3:0] m, int idx);
    vecs[idx].rel = vecs[idx].rel | m;
  endfunction

  function automatic void ev_long(logic [3:0] m, int idx);
    vecs[idx].lng = vecs[idx].lng | m;
  endfunction

  task automatic cmp(input string name, input int idx, input string fld,
                     input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s[%0d] %s: got %b want %b", name, idx, fld, got, want);
    end
  endtask

  task automatic check_out(input string name, input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s[%0d] scoreboard: got empty queue want entry", name, idx);
    end else begin
      e = exp_q.pop_front();
      cmp(name, idx, "press", BTN_PRESS, e.press);
      cmp(name, idx, "rel",   BTN_REL,   e.rel);
      cmp(name, idx, "long",  BTN_LONG,  e.lng);
      cmp(name, idx, "lvl",   BTN_LVL,   e.lvl);
    end
  endtask

  // Drive row i before edge i; outputs after edge i are checked on the following falling edge.
  task automatic apply(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      BTN_IN = vecs[i].btn;
      exp_q.push_back(vecs[i]);
      @(negedge MCLK);
      check_out(name, i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N  = 1'b0;
    BTN_IN = 4'b1111;
    @(negedge MCLK);

    new_seq(10, 4'b1111, 4'b0000);
    apply("rst_hold");

    RST_N = 1'b1;
    new_seq(12, 4'b1111, 4'b0000);
    ev_press(4'b1111, 6);
    set_lvl(4'b1111, 6, 11, 1'b1);
    apply("rst_release");

    new_seq(10, 4'b0000, 4'b1111);
    ev_rel(4'b1111, 6);
    set_lvl(4'b1111, 6, 9, 1'b0);
    apply("all_release");

    new_seq(10, 4'b0100, 4'b0000);
    ev_press(4'b0100, 6);
    set_lvl(4'b0100, 6, 9, 1'b1);
    apply("start_press");

    new_seq(10, 4'b0000, 4'b0100);
    ev_rel(4'b0100, 6);
    set_lvl(4'b0100, 6, 9, 1'b0);
    apply("start_release");

    new_seq(14, 4'b0000, 4'b0000);
    set_btn(4'b0001, 0, 0, 1'b1);
    set_btn(4'b0001, 2, 2, 1'b1);
    set_btn(4'b0001, 4, 13, 1'b1);
    ev_press(4'b0001, 10);
    set_lvl(4'b0001, 10, 13, 1'b1);
    apply("reset_bounce");

    new_seq(10, 4'b0000, 4'b0001);
    ev_rel(4'b0001, 6);
    set_lvl(4'b0001, 6, 9, 1'b0);
    apply("reset_release");

    new_seq(10, 4'b0010, 4'b0000);
    ev_press(4'b0010, 6);
    set_lvl(4'b0010, 6, 9, 1'b1);
    apply("load_press");

    new_seq(14, 4'b0000, 4'b0010);
    set_btn(4'b0010, 2, 2, 1'b1);
    ev_rel(4'b0010, 9);
    set_lvl(4'b0010, 9, 13, 1'b0);
    apply("load_rel_glitch");

    new_seq(50, 4'b0000, 4'b0000);
    set_btn(4'b1001, 0, 39, 1'b1);
    ev_press(4'b1001, 6);
    set_lvl(4'b1001, 6, 45, 1'b1);
    ev_rel(4'b1001, 46);
`ifdef BTN_COND_LONGPRESS_EN
    ev_long(4'b1001, 26);
`endif
    apply("mode_long");

    new_seq(8, 4'b0100, 4'b0000);
    ev_press(4'b0100, 6);
    set_lvl(4'b0100, 6, 7, 1'b1);
    apply("mid_press");

    RST_N = 1'b0;
    new_seq(3, 4'b0100, 4'b0000);
    apply("mid_reset");

    RST_N = 1'b1;
    new_seq(10, 4'b0000, 4'b0000);
    apply("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
